// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and its consumer.
// The generator (master) takes the advance/restart controls and drives
// the sync, blanking, coordinate, event-pulse and frame-index outputs.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CW = 12,
  parameter int FW = 8
);
  logic          en;
  logic          restart;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          line_start;
  logic          frame_start;
  logic          vblank_start;
  logic [FW-1:0] frame_cnt;

  modport master (
    input  en, restart,
    output hsync, vsync, de, pix_x, pix_y,
           line_start, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    output en, restart,
    input  hsync, vsync, de, pix_x, pix_y,
           line_start, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical position counters plus a
// registered decode of sync, active-video, coordinates and event pulses.
// Every output is the decode of the counter state captured on the same
// edge the counters advance, so all outputs lag the counters by one
// cycle and stay mutually aligned.
// Parameter constraints: every porch/sync/display length >= 1 and
// 2**CW > max(H_TOT, V_TOT).
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CW      = 12,
  parameter int FW      = 8
) (
  input logic               clk_25MHz,
  input logic               rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOT  = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT  = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = H_DISP + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;   // exclusive
  localparam int VS_BEG = V_DISP + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;   // exclusive

  typedef logic [CW-1:0] coord_t;
  typedef logic [FW-1:0] frame_t;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_DISP_C = coord_t'(H_DISP);
  localparam coord_t V_DISP_C = coord_t'(V_DISP);
  localparam coord_t HS_BEG_C = coord_t'(HS_BEG);
  localparam coord_t HS_END_C = coord_t'(HS_END);
  localparam coord_t VS_BEG_C = coord_t'(VS_BEG);
  localparam coord_t VS_END_C = coord_t'(VS_END);

  // Registered output bundle; one struct keeps reset/restart/hold uniform.
  typedef struct packed {
    logic   hsync;
    logic   vsync;
    logic   de;
    coord_t pix_x;
    coord_t pix_y;
    logic   line_start;
    logic   frame_start;
    logic   vblank_start;
  } vid_t;

  localparam vid_t VID_RST = '{
    hsync:        ~HS_POL,
    vsync:        ~VS_POL,
    de:           1'b0,
    pix_x:        '0,
    pix_y:        '0,
    line_start:   1'b0,
    frame_start:  1'b0,
    vblank_start: 1'b0
  };

  coord_t h_cnt, v_cnt;
  coord_t h_nxt, v_nxt;
  frame_t frm_q, frm_nxt;
  frame_t frame_cnt_q;
  vid_t   vid_q, vid_d;
  logic   h_wrap, f_wrap;

  // Decode of the current counter position into the next output bundle.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    vid_d              = VID_RST;
    vid_d.de           = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
    if (vid_d.de) begin
      vid_d.pix_x = h_cnt;
      vid_d.pix_y = v_cnt;
    end
    vid_d.hsync        = ((h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C)) ? HS_POL : ~HS_POL;
    vid_d.vsync        = ((v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C)) ? VS_POL : ~VS_POL;
    vid_d.line_start   = (h_cnt == '0);
    vid_d.frame_start  = (h_cnt == '0) && (v_cnt == '0);
    vid_d.vblank_start = (h_cnt == '0) && (v_cnt == V_DISP_C);
  end

  // Next counter position: h wraps every line, v only on the h wrap,
  // and the frame index advances only on the full-frame wrap.
  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    f_wrap  = h_wrap && (v_cnt == V_LAST);
    h_nxt   = h_wrap ? '0 : h_cnt + coord_t'(1);
    v_nxt   = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
    end
    frm_nxt = f_wrap ? frm_q + frame_t'(1) : frm_q;
  end

  // Counter and output registers: restart beats en, en=0 holds all state
  // but clears the single-cycle event pulses.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frm_q       <= '0;
      frame_cnt_q <= '0;
      vid_q       <= VID_RST;
    end else if (vif.restart) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vid_q       <= VID_RST;
    end else if (vif.en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frm_q       <= frm_nxt;
      frame_cnt_q <= frm_q;
      vid_q       <= vid_d;
    end else begin
      vid_q.line_start   <= 1'b0;
      vid_q.frame_start  <= 1'b0;
      vid_q.vblank_start <= 1'b0;
    end
  end

  assign vif.hsync        = vid_q.hsync;
  assign vif.vsync        = vid_q.vsync;
  assign vif.de           = vid_q.de;
  assign vif.pix_x        = vid_q.pix_x;
  assign vif.pix_y        = vid_q.pix_y;
  assign vif.line_start   = vid_q.line_start;
  assign vif.frame_start  = vid_q.frame_start;
  assign vif.vblank_start = vid_q.vblank_start;
  assign vif.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: one default-timing instance and
// one tiny-raster instance (active-high syncs, 2-bit frame index), checked
// with a directed vector table, hand-written corner sequences and random
// en/restart traffic against a linear-position reference model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [11:0] px;
    logic [11:0] py;
    logic       ls;
    logic       fs;
    logic       vbs;
    logic [7:0] fc;
  } exp_t;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
    bit hpol; bit vpol;
    int fw;
  } cfg_t;

  typedef struct packed {
    bit   en;
    bit   rs;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(12), .FW(8)) if_d ();
  vga_timing_gen_if #(.CW(12), .FW(2)) if_s ();

  vga_timing_gen u_dut_d (
    .clk_25MHz (clk),
    .rst_n     (rst_n),
    .vif       (if_d.master)
  );

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(12), .FW(2)
  ) u_dut_s (
    .clk_25MHz (clk),
    .rst_n     (rst_n),
    .vif       (if_s.master)
  );

  int   checks   = 0;
  int   failures = 0;
  cfg_t cfg_d, cfg_s;
  int   pos_d, frm_d, pos_s, frm_s;
  exp_t exp_d, exp_s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // ---------------- reference model (linear raster position) -------------
  function automatic exp_t reset_exp(input cfg_t c, input int fc);
    exp_t e;
    e    = '0;
    e.hs = ~c.hpol;
    e.vs = ~c.vpol;
    e.fc = 8'(fc);
    return e;
  endfunction

  function automatic exp_t decode(input cfg_t c, input int pos, input int frm);
    exp_t e;
    int ht, h, v;
    ht    = c.hd + c.hf + c.hs + c.hb;
    h     = pos % ht;
    v     = pos / ht;
    e.de  = (h < c.hd) && (v < c.vd);
    e.px  = e.de ? 12'(h) : 12'd0;
    e.py  = e.de ? 12'(v) : 12'd0;
    e.hs  = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hpol : ~c.hpol;
    e.vs  = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vpol : ~c.vpol;
    e.ls  = (h == 0);
    e.fs  = (pos == 0);
    e.vbs = (h == 0) && (v == c.vd);
    e.fc  = 8'(frm % (1 << c.fw));
    return e;
  endfunction

  task automatic model_step(input cfg_t c, input bit en, input bit rs,
                            inout int pos, inout int frm, inout exp_t e);
    int tot;
    tot = (c.hd + c.hf + c.hs + c.hb) * (c.vd + c.vf + c.vs + c.vb);
    if (rs) begin
      pos = 0;
      e   = reset_exp(c, int'(e.fc));
    end else if (en) begin
      e = decode(c, pos, frm);
      if (pos == tot - 1) frm++;
      pos = (pos + 1) % tot;
    end else begin
      e.ls  = 1'b0;
      e.fs  = 1'b0;
      e.vbs = 1'b0;
    end
  endtask

  // ---------------- DUT sampling ----------------------------------------
  function automatic exp_t get_d();
    exp_t e;
    e.hs = if_d.hsync;  e.vs = if_d.vsync;  e.de = if_d.de;
    e.px = if_d.pix_x;  e.py = if_d.pix_y;
    e.ls = if_d.line_start;  e.fs = if_d.frame_start;  e.vbs = if_d.vblank_start;
    e.fc = if_d.frame_cnt;
    return e;
  endfunction

  function automatic exp_t get_s();
    exp_t e;
    e.hs = if_s.hsync;  e.vs = if_s.vsync;  e.de = if_s.de;
    e.px = if_s.pix_x;  e.py = if_s.pix_y;
    e.ls = if_s.line_start;  e.fs = if_s.frame_start;  e.vbs = if_s.vblank_start;
    e.fc = {6'd0, if_s.frame_cnt};
    return e;
  endfunction

  function automatic exp_t mk(input bit hs, input bit vs, input bit de, input int px,
                              input int py, input bit ls, input bit fs, input bit vbs,
                              input int fc);
    exp_t e;
    e.hs = hs; e.vs = vs; e.de = de; e.px = 12'(px); e.py = 12'(py);
    e.ls = ls; e.fs = fs; e.vbs = vbs; e.fc = 8'(fc);
    return e;
  endfunction

  // ---------------- stimulus helpers ------------------------------------
  task automatic step_d(input bit en, input bit rs, input string nm);
    if_d.en = en;
    if_d.restart = rs;
    @(posedge clk); #1;
    model_step(cfg_d, en, rs, pos_d, frm_d, exp_d);
    check(nm, 64'(get_d()), 64'(exp_d));
  endtask

  task automatic step_s(input bit en, input bit rs, input string nm);
    if_s.en = en;
    if_s.restart = rs;
    @(posedge clk); #1;
    model_step(cfg_s, en, rs, pos_s, frm_s, exp_s);
    check(nm, 64'(get_s()), 64'(exp_s));
  endtask

  task automatic do_reset();
    if_d.en = 1'b0; if_d.restart = 1'b0;
    if_s.en = 1'b0; if_s.restart = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    pos_d = 0; frm_d = 0; exp_d = reset_exp(cfg_d, 0);
    pos_s = 0; frm_s = 0; exp_s = reset_exp(cfg_s, 0);
    check("reset_d", 64'(get_d()), 64'(exp_d));
    check("reset_s", 64'(get_s()), 64'(exp_s));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    exp_t cur;
    int   hs_low, hs_first, ls_cnt, hs_cnt, vb_first;
    int   last_fs, gaps_bad, pulse_bad, fs_seen;

    cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
    cfg_s = '{8, 1, 1, 1, 4, 1, 1, 1, 1'b1, 1'b1, 2};

    // ---------------- default timing: first lines --------------------------
    do_reset();
    hs_low = 0; hs_first = -1; ls_cnt = 0;
    for (int i = 0; i < 2400; i++) begin
      step_d(1'b1, 1'b0, "run_d");
      cur = get_d();
      if (i < 800 && !cur.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (cur.ls) ls_cnt++;
    end
    check("hsync_low_len_d", 64'(hs_low), 64'(96));
    check("hsync_first_low_d", 64'(hs_first), 64'(656));
    check("line_start_cnt_d", 64'(ls_cnt), 64'(3));

    // restart mid-line (h=300, v=3)
    for (int i = 0; i < 300; i++) step_d(1'b1, 1'b0, "run_d");
    step_d(1'b1, 1'b1, "restart_d");
    cur = get_d();
    check("restart_inactive_d", 64'({cur.de, cur.hs, cur.vs}), 64'(3'b011));
    step_d(1'b1, 1'b0, "after_restart_d");
    cur = get_d();
    check("after_restart_first_d", 64'({cur.fs, cur.ls, cur.de, cur.px, cur.py, cur.fc}),
          64'({3'b111, 12'd0, 12'd0, 8'd0}));

    for (int i = 0; i < 3000; i++)
      step_d(($urandom % 4) != 0, ($urandom % 500) == 0, "random_d");

    // ---------------- tiny raster: directed vector table -------------------
    do_reset();
    tbl[0] = '{1'b1, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[1] = '{1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{1'b1, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[3] = '{1'b1, 1'b0, mk(0, 0, 1, 2, 0, 0, 0, 0, 0)};
    tbl[4] = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6] = '{1'b1, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    tbl[7] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8] = '{1'b1, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    for (int k = 0; k < 9; k++) begin
      if_s.en = tbl[k].en;
      if_s.restart = tbl[k].rs;
      @(posedge clk); #1;
      check($sformatf("vec%0d_s", k), 64'(get_s()), 64'(tbl[k].e));
    end

    // ---------------- tiny raster: frames, sync windows, 3->0 wrap ---------
    do_reset();
    hs_cnt = 0; hs_first = -1; vb_first = -1;
    for (int i = 0; i < 309; i++) begin
      step_s(1'b1, 1'b0, "run_s");
      cur = get_s();
      if (i < 77) begin
        if (cur.hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
        end
        if (cur.vbs && vb_first < 0) vb_first = i;
      end
      if (i == 76)  check("last_pixel_no_fs_s", 64'(cur.fs), 64'(0));
      if (i == 77)  check("corner_wrap_s", 64'({cur.fs, cur.fc}), 64'({1'b1, 8'd1}));
      if (i == 231) check("frame3_s", 64'({cur.fs, cur.fc}), 64'({1'b1, 8'd3}));
      if (i == 308) check("fc_wrap_3_0_s", 64'({cur.fs, cur.fc}), 64'({1'b1, 8'd0}));
    end
    check("hsync_high_cnt_s", 64'(hs_cnt), 64'(7));
    check("hsync_first_high_s", 64'(hs_first), 64'(9));
    check("vblank_start_pos_s", 64'(vb_first), 64'(44));

    // restart at h=3, v=2 with frame index 1
    for (int i = 309; i < 410; i++) step_s(1'b1, 1'b0, "run_s");
    check("fc_before_restart_s", 64'(get_s().fc), 64'(1));
    step_s(1'b1, 1'b1, "restart_s");
    cur = get_s();
    check("restart_inactive_s", 64'({cur.de, cur.hs, cur.vs, cur.fc}), 64'({3'b000, 8'd1}));
    step_s(1'b1, 1'b0, "after_restart_s");
    cur = get_s();
    check("after_restart_first_s", 64'({cur.fs, cur.ls, cur.de, cur.px, cur.py, cur.fc}),
          64'({3'b111, 12'd0, 12'd0, 8'd1}));

    // en toggled every cycle: frame period doubles, pulses dead on en=0
    last_fs = -1; gaps_bad = 0; pulse_bad = 0; fs_seen = 0;
    for (int i = 0; i < 320; i++) begin
      step_s((i % 2) == 0, 1'b0, "toggle_s");
      cur = get_s();
      if ((i % 2) != 0 && (cur.ls || cur.fs || cur.vbs)) pulse_bad++;
      if (cur.fs) begin
        if (last_fs >= 0 && (i - last_fs) != 154) gaps_bad++;
        last_fs = i;
        fs_seen++;
      end
    end
    check("toggle_fs_seen_s", 64'(fs_seen), 64'(2));
    check("toggle_fs_period_s", 64'(gaps_bad), 64'(0));
    check("toggle_pulse_idle_s", 64'(pulse_bad), 64'(0));

    // asynchronous reset mid-line, then recovery
    for (int i = 0; i < 5; i++) step_s(1'b1, 1'b0, "run_s");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_s", 64'(get_s()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    pos_s = 0; frm_s = 0; exp_s = reset_exp(cfg_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_s(1'b1, 1'b0, "post_reset_s");
    cur = get_s();
    check("post_reset_first_s", 64'({cur.fs, cur.ls, cur.de, cur.px, cur.py, cur.fc}),
          64'({3'b111, 12'd0, 12'd0, 8'd0}));

    // random en/restart traffic against the model
    for (int i = 0; i < 2000; i++)
      step_s(($urandom % 4) != 0, ($urandom % 50) == 0, "random_s");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
